// File: rtl/decode_pkg.sv
// Shared decode definitions: opcodes, ALU codes, write-back selects and the control bundle.
// Build option: RV32M_EN adds the multiply/divide fields to the bundle.
package decode_pkg;

  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;

  localparam logic [6:0] F7Base   = 7'b0000000;
  localparam logic [6:0] F7Alt    = 7'b0100000;
  localparam logic [6:0] F7Muldiv = 7'b0000001;

  localparam logic [3:0] AluAnd  = 4'b0000;
  localparam logic [3:0] AluOr   = 4'b0001;
  localparam logic [3:0] AluAdd  = 4'b0010;
  localparam logic [3:0] AluSll  = 4'b0011;
  localparam logic [3:0] AluSub  = 4'b0100;
  localparam logic [3:0] AluSrl  = 4'b0101;
  localparam logic [3:0] AluSltu = 4'b0110;
  localparam logic [3:0] AluXor  = 4'b0111;
  localparam logic [3:0] AluSlt  = 4'b1000;
  localparam logic [3:0] AluSra  = 4'b1001;
  localparam logic [3:0] AluNone = 4'b1111;

  localparam logic [1:0] WbAlu = 2'd0;
  localparam logic [1:0] WbMem = 2'd1;
  localparam logic [1:0] WbPc4 = 2'd2;
  localparam logic [1:0] WbImm = 2'd3;

  typedef struct packed {
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [3:0] alu;
    logic       regwrite;
    logic       imm_sel;
    logic       mem_read;
    logic       mem_write;
    logic [2:0] mem_size;
    logic       branch;
    logic [2:0] branch_type;
    logic       jump;
    logic       jalr;
    logic [1:0] wb_sel;
    logic       pc_src_a;
    logic       illegal;
`ifdef RV32M_EN
    logic       md_en;
    logic [2:0] md_op;
`endif
  } ctrl_t;

  // funct3 -> ALU op; alt selects SUB/SRA (instr bit 30)
  function automatic logic [3:0] alu_op(input logic [2:0] funct3, input logic alt);
    logic [3:0] op;
    case (funct3)
      3'b000:  op = alt ? AluSub : AluAdd;
      3'b001:  op = AluSll;
      3'b010:  op = AluSlt;
      3'b011:  op = AluSltu;
      3'b100:  op = AluXor;
      3'b101:  op = alt ? AluSra : AluSrl;
      3'b110:  op = AluOr;
      default: op = AluAnd;
    endcase
    return op;
  endfunction

  function automatic ctrl_t reset_ctrl();
    ctrl_t c;
    c     = '0;
    c.alu = AluNone;
    return c;
  endfunction

endpackage

// File: rtl/decode_if.sv
// Fetch-side and execute-side handshake/bundle signals of the decode stage.
// Build option: RV32M_EN adds md_en/md_op.
interface decode_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [XLEN-1:0]  in_pc;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_pc;
  logic [4:0]       out_rd;
  logic [4:0]       out_rs1;
  logic [4:0]       out_rs2;
  logic [XLEN-1:0]  out_imm;
  logic [3:0]       alu_control;
  logic             regwrite;
  logic             imm_sel;
  logic             mem_read;
  logic             mem_write;
  logic [2:0]       mem_size;
  logic             branch;
  logic [2:0]       branch_type;
  logic             jump;
  logic             jalr;
  logic [1:0]       wb_sel;
  logic             pc_src_a;
  logic             illegal;
  logic [CNT_W-1:0] decoded_cnt;
  logic [CNT_W-1:0] illegal_cnt;
`ifdef RV32M_EN
  logic             md_en;
  logic [2:0]       md_op;
`endif

  // Drives instructions in and consumes the bundle
  modport master (
`ifdef RV32M_EN
    input  md_en, md_op,
`endif
    output in_valid, in_instr, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_pc, out_rd, out_rs1, out_rs2, out_imm, alu_control,
    input  regwrite, imm_sel, mem_read, mem_write, mem_size, branch, branch_type, jump, jalr,
    input  wb_sel, pc_src_a, illegal, decoded_cnt, illegal_cnt
  );

  // The decode stage itself
  modport slave (
`ifdef RV32M_EN
    output md_en, md_op,
`endif
    input  in_valid, in_instr, in_pc, flush, out_ready,
    output in_ready, out_valid, out_pc, out_rd, out_rs1, out_rs2, out_imm, alu_control,
    output regwrite, imm_sel, mem_read, mem_write, mem_size, branch, branch_type, jump, jalr,
    output wb_sel, pc_src_a, illegal, decoded_cnt, illegal_cnt
  );
endinterface

// File: rtl/decode_comb.sv
// Purely combinational RV32I instruction -> control bundle and sign-extended immediate.
// Build option: RV32M_EN makes OP funct7=0000001 legal and fills md_en/md_op.
module decode_comb
  import decode_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     instr,
  output ctrl_t           ctrl,
  output logic [XLEN-1:0] imm
);

  logic [6:0]  opcode;
  logic [6:0]  funct7;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] imm_raw;
  logic        legal;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  // Decode by opcode, then squash everything but the illegal flag if undecodable
  always_comb begin
    ctrl     = '0;
    ctrl.alu = AluNone;
    imm_raw  = '0;
    legal    = 1'b0;
    case (opcode)
      OpR: begin
        ctrl.regwrite = 1'b1;
        if (funct7 == F7Base) begin
          legal    = 1'b1;
          ctrl.alu = alu_op(funct3, 1'b0);
        end else if (funct7 == F7Alt && (funct3 == 3'b000 || funct3 == 3'b101)) begin
          legal    = 1'b1;
          ctrl.alu = alu_op(funct3, 1'b1);
        end
`ifdef RV32M_EN
        else if (funct7 == F7Muldiv) begin
          legal      = 1'b1;
          ctrl.md_en = 1'b1;
          ctrl.md_op = funct3;
        end
`endif
      end
      OpImm: begin
        // funct7 only matters for the shift-immediate forms
        legal = 1'b1;
        if (funct3 == 3'b001) legal = (funct7 == F7Base);
        if (funct3 == 3'b101) legal = (funct7 == F7Base) || (funct7 == F7Alt);
        ctrl.alu      = alu_op(funct3, (funct3 == 3'b101) && funct7[5]);
        ctrl.regwrite = 1'b1;
        ctrl.imm_sel  = 1'b1;
        imm_raw       = imm_i;
      end
      OpLoad: begin
        legal         = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
        ctrl.alu      = AluAdd;
        ctrl.regwrite = 1'b1;
        ctrl.imm_sel  = 1'b1;
        ctrl.mem_read = 1'b1;
        ctrl.mem_size = funct3;
        ctrl.wb_sel   = WbMem;
        imm_raw       = imm_i;
      end
      OpStore: begin
        legal          = (funct3 <= 3'b010);
        ctrl.alu       = AluAdd;
        ctrl.imm_sel   = 1'b1;
        ctrl.mem_write = 1'b1;
        ctrl.mem_size  = funct3;
        imm_raw        = imm_s;
      end
      OpBranch: begin
        legal            = (funct3 != 3'b010) && (funct3 != 3'b011);
        ctrl.branch      = 1'b1;
        ctrl.branch_type = funct3;
        imm_raw          = imm_b;
      end
      OpJal: begin
        legal         = 1'b1;
        ctrl.jump     = 1'b1;
        ctrl.regwrite = 1'b1;
        ctrl.wb_sel   = WbPc4;
        imm_raw       = imm_j;
      end
      OpJalr: begin
        legal         = (funct3 == 3'b000);
        ctrl.alu      = AluAdd;
        ctrl.jump     = 1'b1;
        ctrl.jalr     = 1'b1;
        ctrl.regwrite = 1'b1;
        ctrl.imm_sel  = 1'b1;
        ctrl.wb_sel   = WbPc4;
        imm_raw       = imm_i;
      end
      OpLui: begin
        legal         = 1'b1;
        ctrl.regwrite = 1'b1;
        ctrl.wb_sel   = WbImm;
        imm_raw       = imm_u;
      end
      OpAuipc: begin
        legal         = 1'b1;
        ctrl.alu      = AluAdd;
        ctrl.regwrite = 1'b1;
        ctrl.imm_sel  = 1'b1;
        ctrl.pc_src_a = 1'b1;
        imm_raw       = imm_u;
      end
      default: legal = 1'b0;
    endcase

    if (!legal) begin
      ctrl         = '0;
      ctrl.alu     = AluNone;
      ctrl.illegal = 1'b1;
      imm_raw      = '0;
    end
    // Register indices are raw fields; rd is zeroed when nothing is written back
    ctrl.rs1 = instr[19:15];
    ctrl.rs2 = instr[24:20];
    ctrl.rd  = ctrl.regwrite ? instr[11:7] : 5'd0;
  end

  assign imm = XLEN'($signed(imm_raw));

endmodule

// File: rtl/decode_stage.sv
// Registered RV32I decode stage: one pipeline register with valid/ready, flush,
// illegal detection and saturating accept/illegal counters.
// Build option: RV32M_EN enables the multiply/divide decode and md_en/md_op outputs.
module decode_stage
  import decode_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
) (
  input logic     clk,
  input logic     rst_n,
  decode_if.slave bus
);

  ctrl_t            dec_ctrl;
  logic [XLEN-1:0]  dec_imm;

  ctrl_t            ctrl_q;
  logic [XLEN-1:0]  pc_q;
  logic [XLEN-1:0]  imm_q;
  logic             valid_q;
  logic [CNT_W-1:0] dec_cnt_q;
  logic [CNT_W-1:0] ill_cnt_q;

  logic             ready;
  logic             accept;
  logic             count_en;

  decode_comb #(
    .XLEN(XLEN)
  ) u_decode_comb (
    .instr(bus.in_instr),
    .ctrl (dec_ctrl),
    .imm  (dec_imm)
  );

  assign ready    = !valid_q || bus.out_ready;
  assign accept   = bus.in_valid && ready;
  // An instruction arriving in a flush cycle is discarded and never counted
  assign count_en = accept && !bus.flush;

  // Pipeline register: flush wins, then load on accept, else drain on out_ready
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      ctrl_q  <= reset_ctrl();
      pc_q    <= '0;
      imm_q   <= '0;
    end else if (bus.flush) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q <= 1'b1;
      ctrl_q  <= dec_ctrl;
      pc_q    <= bus.in_pc;
      imm_q   <= dec_imm;
    end else if (bus.out_ready) begin
      valid_q <= 1'b0;
    end
  end

  // Saturating event counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dec_cnt_q <= '0;
      ill_cnt_q <= '0;
    end else if (count_en) begin
      if (dec_cnt_q != '1) dec_cnt_q <= dec_cnt_q + CNT_W'(1);
      if (dec_ctrl.illegal && ill_cnt_q != '1) ill_cnt_q <= ill_cnt_q + CNT_W'(1);
    end
  end

  assign bus.in_ready    = ready;
  assign bus.out_valid   = valid_q;
  assign bus.out_pc      = pc_q;
  assign bus.out_imm     = imm_q;
  assign bus.out_rd      = ctrl_q.rd;
  assign bus.out_rs1     = ctrl_q.rs1;
  assign bus.out_rs2     = ctrl_q.rs2;
  assign bus.alu_control = ctrl_q.alu;
  assign bus.regwrite    = ctrl_q.regwrite;
  assign bus.imm_sel     = ctrl_q.imm_sel;
  assign bus.mem_read    = ctrl_q.mem_read;
  assign bus.mem_write   = ctrl_q.mem_write;
  assign bus.mem_size    = ctrl_q.mem_size;
  assign bus.branch      = ctrl_q.branch;
  assign bus.branch_type = ctrl_q.branch_type;
  assign bus.jump        = ctrl_q.jump;
  assign bus.jalr        = ctrl_q.jalr;
  assign bus.wb_sel      = ctrl_q.wb_sel;
  assign bus.pc_src_a    = ctrl_q.pc_src_a;
  assign bus.illegal     = ctrl_q.illegal;
  assign bus.decoded_cnt = dec_cnt_q;
  assign bus.illegal_cnt = ill_cnt_q;
`ifdef RV32M_EN
  assign bus.md_en       = ctrl_q.md_en;
  assign bus.md_op       = ctrl_q.md_op;
`endif

endmodule
